// File: rtl/vga_sync_generator.sv
// Free-running 800x600@72 VGA timing generator: registered sync, coordinates and visible flag.
// Optional macro VGA_SYNC_FRAME_COUNT_EN adds a 16-bit completed-frame counter output.
module vga_sync_generator #(
    parameter int HOR_VISIBLE = 800,
    parameter int HOR_FRONT   = 56,
    parameter int HOR_SYNC    = 120,
    parameter int HOR_BACK    = 64,
    parameter int VER_VISIBLE = 600,
    parameter int VER_FRONT   = 37,
    parameter int VER_SYNC    = 6,
    parameter int VER_BACK    = 23,
    parameter bit HSYNC_POL   = 1'b1,
    parameter bit VSYNC_POL   = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] display_col,
    output logic [10:0] display_row,
    output logic        visible,
    output logic        line_start,
    output logic        frame_start
`ifdef VGA_SYNC_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam int HOR_TOTAL = HOR_VISIBLE + HOR_FRONT + HOR_SYNC + HOR_BACK;
    localparam int VER_TOTAL = VER_VISIBLE + VER_FRONT + VER_SYNC + VER_BACK;

    localparam logic [11:0] H_LAST     = 12'(HOR_TOTAL - 1);
    localparam logic [11:0] H_VIS      = 12'(HOR_VISIBLE);
    localparam logic [11:0] HS_START   = 12'(HOR_VISIBLE + HOR_FRONT);
    localparam logic [11:0] HS_END     = 12'(HOR_VISIBLE + HOR_FRONT + HOR_SYNC);
    localparam logic [10:0] V_LAST     = 11'(VER_TOTAL - 1);
    localparam logic [10:0] V_VIS      = 11'(VER_VISIBLE);
    localparam logic [10:0] VS_START   = 11'(VER_VISIBLE + VER_FRONT);
    localparam logic [10:0] VS_END     = 11'(VER_VISIBLE + VER_FRONT + VER_SYNC);

    logic [11:0] h_cnt, h_next;
    logic [10:0] v_cnt, v_next;
    logic        h_wrap;
    logic        in_hsync, in_vsync;

    always_comb begin
        h_wrap   = (h_cnt == H_LAST);
        h_next   = h_wrap ? 12'd0 : h_cnt + 12'd1;
        v_next   = v_cnt;
        if (h_wrap) begin
            v_next = (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
        end
        in_hsync = (h_cnt >= HS_START) && (h_cnt < HS_END);
        in_vsync = (v_cnt >= VS_START) && (v_cnt < VS_END);
    end

    // Outputs decode the pre-update counters, so everything lands on the same edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            h_cnt       <= 12'd0;
            v_cnt       <= 11'd0;
            display_col <= 12'd0;
            display_row <= 11'd0;
            visible     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= !HSYNC_POL;
            vsync       <= !VSYNC_POL;
        end else if (enable) begin
            h_cnt       <= h_next;
            v_cnt       <= v_next;
            display_col <= h_cnt;
            display_row <= v_cnt;
            visible     <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
            line_start  <= (h_cnt == 12'd0);
            frame_start <= (h_cnt == 12'd0) && (v_cnt == 11'd0);
            hsync       <= in_hsync ? HSYNC_POL : !HSYNC_POL;
            vsync       <= in_vsync ? VSYNC_POL : !VSYNC_POL;
        end
    end

`ifdef VGA_SYNC_FRAME_COUNT_EN
    // Counts on the edge where the counters roll over from the last pixel of the frame.
    always_ff @(posedge clock) begin
        if (!reset) begin
            frame_count <= 16'd0;
        end else if (enable && h_wrap && (v_cnt == V_LAST)) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_generator.sv
// Directed bench: full-size instance for line timing and enable freeze,
// a shrunken inverted-polarity instance for whole-frame, vsync and mid-frame reset.
module tb_vga_sync_generator;

    logic clock = 1'b0;
    always #10 clock = ~clock;

    logic        reset_a, enable_a, hs_a, vs_a, vis_a, ls_a, fs_a;
    logic [11:0] col_a;
    logic [10:0] row_a;
    logic        reset_b, enable_b, hs_b, vs_b, vis_b, ls_b, fs_b;
    logic [11:0] col_b;
    logic [10:0] row_b;
`ifdef VGA_SYNC_FRAME_COUNT_EN
    logic [15:0] fc_a, fc_b;
`endif

    vga_sync_generator dut_a (
        .clock(clock), .reset(reset_a), .enable(enable_a),
        .hsync(hs_a), .vsync(vs_a), .display_col(col_a), .display_row(row_a),
        .visible(vis_a), .line_start(ls_a), .frame_start(fs_a)
`ifdef VGA_SYNC_FRAME_COUNT_EN
        , .frame_count(fc_a)
`endif
    );

    // Small frame: HOR_TOTAL 15 (hsync cols 10..12), VER_TOTAL 8 (vsync rows 5..6), active-low syncs.
    vga_sync_generator #(
        .HOR_VISIBLE(8), .HOR_FRONT(2), .HOR_SYNC(3), .HOR_BACK(2),
        .VER_VISIBLE(4), .VER_FRONT(1), .VER_SYNC(2), .VER_BACK(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut_b (
        .clock(clock), .reset(reset_b), .enable(enable_b),
        .hsync(hs_b), .vsync(vs_b), .display_col(col_b), .display_row(row_b),
        .visible(vis_b), .line_start(ls_b), .frame_start(fs_b)
`ifdef VGA_SYNC_FRAME_COUNT_EN
        , .frame_count(fc_b)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          n;
        logic [11:0] col;
        logic [10:0] row;
        logic        hs;
        logic        vis;
        logic        ls;
        logic        fs;
    } vec_t;

    vec_t vecs[12];

    // Expected packed outputs of dut_b after k enable edges since reset release.
    function automatic logic [27:0] model_b(input int k);
        int p, c, r;
        logic hs, vs, vis, ls, fs;
        p   = (k - 1) % 120;
        c   = p % 15;
        r   = p / 15;
        hs  = !(c >= 10 && c <= 12);
        vs  = !(r >= 5 && r <= 6);
        vis = (c < 8) && (r < 4);
        ls  = (c == 0);
        fs  = (c == 0) && (r == 0);
        return {12'(c), 11'(r), hs, vs, vis, ls, fs};
    endfunction

    task automatic run_b(input int from_k, input int to_k);
        for (int k = from_k; k <= to_k; k++) begin
            @(posedge clock);
            @(negedge clock);
            check("b_frame", {col_b, row_b, hs_b, vs_b, vis_b, ls_b, fs_b}, model_b(k));
`ifdef VGA_SYNC_FRAME_COUNT_EN
            check("b_frame_count", fc_b, 64'(k / 120));
`endif
        end
    endtask

    initial begin
        int cur;
        vecs[0]  = '{1,    12'd0,    11'd0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{2,    12'd1,    11'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{800,  12'd799,  11'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{801,  12'd800,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{856,  12'd855,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{857,  12'd856,  11'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{976,  12'd975,  11'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{977,  12'd976,  11'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1040, 12'd1039, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1041, 12'd0,    11'd1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1042, 12'd1,    11'd1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1896, 12'd855,  11'd1, 1'b0, 1'b0, 1'b0, 1'b0};

        reset_a = 1'b0; enable_a = 1'b1;
        reset_b = 1'b0; enable_b = 1'b1;
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("a_reset", {col_a, row_a, vis_a, hs_a, vs_a, ls_a, fs_a}, 64'd0);

        reset_a = 1'b1;
        cur = 0;
        for (int i = 0; i < 12; i++) begin
            while (cur < vecs[i].n) begin
                @(posedge clock);
                cur++;
            end
            @(negedge clock);
            check($sformatf("a_vec%0d", i),
                  {col_a, row_a, hs_a, vs_a, vis_a, ls_a, fs_a},
                  {vecs[i].col, vecs[i].row, vecs[i].hs, 1'b0, vecs[i].vis, vecs[i].ls, vecs[i].fs});
        end

        // Freeze at col 855 of row 1, then confirm hsync and line length resume unchanged.
        enable_a = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clock);
            @(negedge clock);
            check("a_freeze", {col_a, row_a, hs_a, vis_a, ls_a}, {12'd855, 11'd1, 1'b0, 1'b0, 1'b0});
        end
        enable_a = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cur++;
        check("a_resume_hsync", {col_a, hs_a}, {12'd856, 1'b1});
        while (cur < 2080) begin
            @(posedge clock);
            cur++;
        end
        @(negedge clock);
        check("a_line_end", {col_a, row_a}, {12'd1039, 11'd1});
        @(posedge clock);
        @(negedge clock);
        check("a_line_wrap", {col_a, row_a, ls_a}, {12'd0, 11'd2, 1'b1});

        // Small instance: reset levels with inverted polarity, two frames and a bit.
        check("b_reset", {col_b, row_b, hs_b, vs_b, vis_b, ls_b, fs_b}, {23'd0, 1'b1, 1'b1, 3'b000});
        reset_b = 1'b1;
        run_b(1, 327);
        check("b_both_sync_active", {col_b, row_b, hs_b, vs_b}, {12'd11, 11'd5, 1'b0, 1'b0});

        reset_b = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("b_mid_reset", {col_b, row_b, hs_b, vs_b, vis_b, ls_b, fs_b}, {23'd0, 1'b1, 1'b1, 3'b000});
`ifdef VGA_SYNC_FRAME_COUNT_EN
        check("b_mid_reset_fc", fc_b, 64'd0);
`endif
        reset_b = 1'b1;
        run_b(1, 121);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
